spart_bus_arbiter: RTL and testbench
====================================

Name: spart_bus_arbiter

Overview:
- Owns the SPART register bus (iocs, iorw, ioaddr, databus).
- Shares the bus between two client masters (c0, c1) with round-robin arbitration.
- Performs baud-divisor programming after reset and whenever br_cfg changes.
- Sits between the SPART and its drivers; clients never see the divisor registers or the tri-state bus.

Parameters:
- DIV0, 16'd1301, divisor for br_cfg=00
- DIV1, 16'd650, divisor for br_cfg=01
- DIV2, 16'd325, divisor for br_cfg=10
- DIV3, 16'd162, divisor for br_cfg=11

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- br_cfg  in  2  baud select
- c0_req, c1_req  in  1  client request; held high until the matching ack
- c0_we, c1_we  in  1  1=write, 0=read
- c0_addr, c1_addr  in  2  SPART address; 00=TX/RX buffer, 01=status, 1x=illegal for clients
- c0_wdata, c1_wdata  in  8  write data
- c0_ack, c1_ack  out  1  one-cycle completion pulse
- c0_err, c1_err  out  1  valid with ack; 1=illegal address, no bus cycle issued
- c0_rdata, c1_rdata  out  8  read data, valid with ack
- cfg_done  out  1  divisor programmed for the current br_cfg
- iocs  out  1  SPART chip select
- iorw  out  1  1=read, 0=write
- ioaddr  out  2  SPART register address
- databus  inout  8  driven only when iocs=1 and iorw=0, else high-Z

Behaviour:
- Reset values:
  - iocs=0, iorw=1, ioaddr=00, databus=Z.
  - All acks, errs and cfg_done =0; rdata=0.
  - last_grant=1, so c0 wins the first tie.
  - br_cfg_q<=br_cfg; state=CFG_LO.
- Registered outputs: iocs, iorw, ioaddr and the internal write register are registered. Each bus access lasts exactly one cycle.
- States:
  - CFG_LO:
    - Drive iocs=1, iorw=0, ioaddr=10, data=div[7:0].
    - Next state is CFG_HI.
  - CFG_HI:
    - Drive ioaddr=11, data=div[15:8].
    - Next state is IDLE.
    - Set cfg_done=1 on entry to IDLE.
  - IDLE:
    - iocs=0, iorw=1.
    - Priority order:
      1. If cfg_pending: cfg_done<=0, go to CFG_LO.
      2. Else if any req: pick the winner, latch we/addr/wdata, set last_grant<=winner.
    - Winner with legal address: go to ACCESS.
    - Winner with illegal address: go to DONE with err.
  - ACCESS:
    - iocs=1, iorw=~we, ioaddr=addr; databus=wdata when writing.
    - On read, sample databus at the closing clock edge.
    - Next state is DONE.
  - DONE:
    - iocs=0; pulse winner ack, plus err if flagged.
    - rdata = sampled byte; 0 on write or err.
    - Requests are ignored in this state. Next state is IDLE.
- Latency: request seen in IDLE cycle N, bus active N+1, ack N+2. Clients must drop req by N+3. Peak throughput is 1 transaction per 3 cycles.
- Arbitration:
  - Single requester: grant it.
  - Both requesting: grant ~last_grant.
  - Illegal-address grants still update last_grant.
- Divisor select: div = DIV[br_cfg_q].
- Reconfiguration:
  - br_cfg != br_cfg_q sets cfg_pending and updates br_cfg_q.
  - The in-flight ACCESS/DONE completes first; reconfiguration is taken at the next IDLE.
  - A change during CFG_LO/CFG_HI sets pending, and the full LO/HI pair is re-run with the new value.
  - Requests wait during configuration; no request is lost.
- Reset mid-transaction:
  - The transaction is abandoned and no ack is issued.
  - Bus returns to idle values next cycle; configuration restarts.
- The other client's ack/err/rdata stay 0 while a transaction is in progress.

Decomposition:
- spart_pkg:
  - Address constants: ADDR_BUF=00, ADDR_STAT=01, ADDR_DIVLO=10, ADDR_DIVHI=11.
  - Default divisor constants.
  - State enum: CFG_LO, CFG_HI, IDLE, ACCESS, DONE.
- Sub-module spart_rr_arb2:
  - Combinational 2-way round-robin pick.
  - Inputs: req[1:0], last_grant. Outputs: grant_valid, grant_id.
- Top holds the FSM, the bus registers and the tri-state.

Test Plan:
- Reset release with br_cfg=01 -> cycle 1 ioaddr=10, databus=0x8A, iorw=0; cycle 2 ioaddr=11, databus=0x02; cfg_done=1 from cycle 3.
- After cfg, c0 writes addr 00 data 0x41 -> one cycle iocs=1, iorw=0, ioaddr=00, databus=0x41; c0_ack next cycle, err=0.
- c1 reads addr 01 while SPART drives 0xC3 -> iorw=1, databus Z from arbiter; c1_ack with c1_rdata=0xC3.
- c0 and c1 requesting continuously -> grants alternate c0, c1, c0, c1; acks spaced 3 cycles apart.
- c1 writes addr 10 -> no iocs pulse; c1_ack=1, c1_err=1, c1_rdata=0.
- br_cfg 01->00 during a c0 ACCESS -> c0 ack completes; then cfg_done=0; then writes 0x15 to 10 and 0x05 to 11; cfg_done=1; a held c1 request is served afterwards.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus arbiter.
//   - SPART register addresses as seen on ioaddr
//   - default baud divisors for the four br_cfg settings
//   - FSM state encoding and small helpers used by the top level
package spart_pkg;

  typedef logic [1:0] spart_addr_t;
  typedef logic [7:0] spart_byte_t;

  localparam spart_addr_t ADDR_BUF   = 2'b00;
  localparam spart_addr_t ADDR_STAT  = 2'b01;
  localparam spart_addr_t ADDR_DIVLO = 2'b10;
  localparam spart_addr_t ADDR_DIVHI = 2'b11;

  localparam logic [15:0] DIV0_DEFAULT = 16'd1301;
  localparam logic [15:0] DIV1_DEFAULT = 16'd650;
  localparam logic [15:0] DIV2_DEFAULT = 16'd325;
  localparam logic [15:0] DIV3_DEFAULT = 16'd162;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    ACCESS,
    DONE
  } state_t;

  // Clients may only touch the data buffer and the status register; the
  // divisor registers belong to the arbiter.
  function automatic logic addr_is_legal(input spart_addr_t addr);
    return (addr == ADDR_BUF) || (addr == ADDR_STAT);
  endfunction

endpackage

// File: rtl/spart_bus_arbiter_if.sv
// Client-side handshake bundle for the SPART bus arbiter.
//   master modport: a pair of client drivers (c0, c1)
//     out: cX_req, cX_we, cX_addr, cX_wdata
//     in : cX_ack, cX_err, cX_rdata
//   slave modport : the arbiter (directions mirrored)
interface spart_bus_arbiter_if;
  import spart_pkg::*;

  logic        c0_req;
  logic        c0_we;
  spart_addr_t c0_addr;
  spart_byte_t c0_wdata;
  logic        c0_ack;
  logic        c0_err;
  spart_byte_t c0_rdata;

  logic        c1_req;
  logic        c1_we;
  spart_addr_t c1_addr;
  spart_byte_t c1_wdata;
  logic        c1_ack;
  logic        c1_err;
  spart_byte_t c1_rdata;

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    output c1_req, c1_we, c1_addr, c1_wdata,
    input  c0_ack, c0_err, c0_rdata,
    input  c1_ack, c1_err, c1_rdata
  );

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    output c0_ack, c0_err, c0_rdata,
    output c1_ack, c1_err, c1_rdata
  );

endinterface

// File: rtl/spart_rr_arb2.sv
// Two-way round-robin pick, purely combinational.
//   req[1:0]    : request from client 1 / client 0
//   last_grant  : id of the client granted most recently
//   grant_valid : at least one request present
//   grant_id    : winning client (meaningful only with grant_valid)
module spart_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      // On a tie the client that did not win last time goes first.
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/spart_bus_arbiter.sv
// SPART register-bus owner. Programs the baud divisor after reset and on
// every br_cfg change, and shares the bus between two clients with
// round-robin arbitration.
//   clk, rst  : clock, synchronous active-high reset
//   br_cfg    : baud select (chooses DIV0..DIV3)
//   cli       : client handshake bundle (slave side)
//   cfg_done  : divisor programmed for the current br_cfg
//   iocs, iorw, ioaddr, databus : SPART register bus (databus tri-state)
module spart_bus_arbiter
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV0 = DIV0_DEFAULT,
  parameter logic [15:0] DIV1 = DIV1_DEFAULT,
  parameter logic [15:0] DIV2 = DIV2_DEFAULT,
  parameter logic [15:0] DIV3 = DIV3_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          br_cfg,
  spart_bus_arbiter_if.slave  cli,
  output logic                cfg_done,
  output logic                iocs,
  output logic                iorw,
  output logic [1:0]          ioaddr,
  inout  wire  [7:0]          databus
);

  state_t      state_q, state_d;
  logic [1:0]  br_cfg_q;
  logic        cfg_pending_q;
  logic        cfg_done_q, cfg_done_d;
  logic        last_grant_q, last_grant_d;

  logic        iocs_q, iocs_d;
  logic        iorw_q, iorw_d;
  spart_addr_t ioaddr_q, ioaddr_d;
  spart_byte_t wdata_q, wdata_d;

  // Latched transaction context for the client being served.
  logic        we_q, we_d;
  logic        gid_q, gid_d;

  // Response launched toward one client at the next edge.
  logic        resp_fire;
  logic        resp_id;
  logic        resp_err;
  spart_byte_t resp_rdata;

  logic [1:0]       ack_d, ack_q;
  logic [1:0]       err_d, err_q;
  logic [1:0][7:0]  rdata_d, rdata_q;

  logic [15:0] div;
  logic [1:0]  req_vec;
  logic        grant_valid;
  logic        grant_id;
  logic        sel_we;
  spart_addr_t sel_addr;
  spart_byte_t sel_wdata;

  assign req_vec = {cli.c1_req, cli.c0_req};

  spart_rr_arb2 u_arb (
    .req         (req_vec),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_we    = grant_id ? cli.c1_we    : cli.c0_we;
  assign sel_addr  = grant_id ? cli.c1_addr  : cli.c0_addr;
  assign sel_wdata = grant_id ? cli.c1_wdata : cli.c0_wdata;

  always_comb begin
    case (br_cfg_q)
      2'b00:   div = DIV0;
      2'b01:   div = DIV1;
      2'b10:   div = DIV2;
      default: div = DIV3;
    endcase
  end

  // Track br_cfg. A new value always re-arms programming; the pending flag
  // is only consumed in IDLE so an in-flight access finishes first, and a
  // change seen mid-programming forces a complete LO/HI rerun.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cfg_q      <= br_cfg;
      cfg_pending_q <= 1'b0;
    end else if (br_cfg != br_cfg_q) begin
      br_cfg_q      <= br_cfg;
      cfg_pending_q <= 1'b1;
    end else if (state_q == IDLE && cfg_pending_q) begin
      cfg_pending_q <= 1'b0;
    end
  end

  // Every state decides the bus values for the following cycle, so a bus
  // write launched from CFG_LO/CFG_HI/IDLE is on the pins while the FSM is
  // already one step further along.
  always_comb begin
    state_d      = state_q;
    cfg_done_d   = cfg_done_q;
    last_grant_d = last_grant_q;
    iocs_d       = 1'b0;
    iorw_d       = 1'b1;
    ioaddr_d     = ioaddr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    gid_d        = gid_q;
    resp_fire    = 1'b0;
    resp_id      = gid_q;
    resp_err     = 1'b0;
    resp_rdata   = '0;

    case (state_q)
      CFG_LO: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DIVLO;
        wdata_d  = div[7:0];
        state_d  = CFG_HI;
      end

      CFG_HI: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DIVHI;
        wdata_d  = div[15:8];
        state_d  = IDLE;
      end

      IDLE: begin
        if (cfg_pending_q) begin
          cfg_done_d = 1'b0;
          state_d    = CFG_LO;
        end else begin
          // The first IDLE cycle follows the DIVHI write, so the divisor is
          // in place by now unless br_cfg is moving under us this cycle.
          cfg_done_d = (br_cfg == br_cfg_q);
          if (grant_valid) begin
            gid_d        = grant_id;
            last_grant_d = grant_id;
            we_d         = sel_we;
            wdata_d      = sel_wdata;
            if (addr_is_legal(sel_addr)) begin
              iocs_d   = 1'b1;
              iorw_d   = ~sel_we;
              ioaddr_d = sel_addr;
              state_d  = ACCESS;
            end else begin
              // Illegal address: answer straight away without a bus cycle.
              resp_fire = 1'b1;
              resp_id   = grant_id;
              resp_err  = 1'b1;
              state_d   = DONE;
            end
          end
        end
      end

      ACCESS: begin
        // Read data is captured at the edge that closes the bus cycle.
        resp_fire  = 1'b1;
        resp_id    = gid_q;
        resp_rdata = we_q ? 8'h00 : databus;
        state_d    = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = CFG_LO;
      end
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign ack_d[gi]   = resp_fire && (resp_id == 1'(gi));
    assign err_d[gi]   = resp_fire && (resp_id == 1'(gi)) && resp_err;
    assign rdata_d[gi] = (resp_fire && (resp_id == 1'(gi))) ? resp_rdata : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CFG_LO;
      cfg_done_q   <= 1'b0;
      last_grant_q <= 1'b1;
      iocs_q       <= 1'b0;
      iorw_q       <= 1'b1;
      ioaddr_q     <= ADDR_BUF;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      gid_q        <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cfg_done_q   <= cfg_done_d;
      last_grant_q <= last_grant_d;
      iocs_q       <= iocs_d;
      iorw_q       <= iorw_d;
      ioaddr_q     <= ioaddr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      gid_q        <= gid_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign cfg_done = cfg_done_q;
  assign iocs     = iocs_q;
  assign iorw     = iorw_q;
  assign ioaddr   = ioaddr_q;
  assign databus  = (iocs_q && !iorw_q) ? wdata_q : 8'hzz;

  assign cli.c0_ack   = ack_q[0];
  assign cli.c0_err   = err_q[0];
  assign cli.c0_rdata = rdata_q[0];
  assign cli.c1_ack   = ack_q[1];
  assign cli.c1_err   = err_q[1];
  assign cli.c1_rdata = rdata_q[1];

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Scoreboard bench for spart_bus_arbiter: stimulus queues expected bus
// cycles, acks and cfg_done edges (with the cycle they must appear in);
// a monitor pops and compares whenever the DUT shows one of them.
module tb_spart_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic       cfg_done;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] spart_data;

  spart_bus_arbiter_if bus_if ();

  spart_bus_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .cli      (bus_if),
    .cfg_done (cfg_done),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus)
  );

  // SPART model: drives the bus for reads of its registers.
  assign databus = (iocs && iorw) ? spart_data : 8'hzz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = cfg_done edge, 1 = bus cycle, 2 = client response
  typedef struct {
    int          kind;
    int          cyc;
    logic [19:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic void push(input int kind, input int c, input logic [19:0] v);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    sb_q.push_back(e);
  endfunction

  function automatic void push_cfg(input int c, input logic v);
    push(0, c, {19'b0, v});
  endfunction

  function automatic void push_bus(input int c, input logic rw, input logic [1:0] a, input logic [7:0] d);
    push(1, c, {9'b0, rw, a, d});
  endfunction

  function automatic void push_ack(input int c, input int id, input logic err, input logic [7:0] rd);
    if (id == 0) push(2, c, {1'b1, err, rd, 10'b0});
    else         push(2, c, {10'b0, 1'b1, err, rd});
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic sb_compare(input int kind, input logic [19:0] got);
    exp_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected got kind=%0d val=%h cyc=%0d want nothing", kind, got, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.val !== got || (e.cyc >= 0 && e.cyc != cyc)) begin
        n_fail++;
        $display("FAIL sb_event got kind=%0d val=%h cyc=%0d want kind=%0d val=%h cyc=%0d",
                 kind, got, cyc, e.kind, e.val, e.cyc);
      end else begin
        $display("ok kind=%0d val=%h cyc=%0d", kind, got, cyc);
      end
    end
  endtask

  // Monitor: cfg edges, then bus cycles, then responses within one cycle.
  initial begin
    logic prev_cfg;
    prev_cfg = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (cfg_done != prev_cfg) sb_compare(0, {19'b0, cfg_done});
      prev_cfg = cfg_done;
      if (iocs) sb_compare(1, {9'b0, iorw, ioaddr, databus});
      if (bus_if.c0_ack || bus_if.c1_ack)
        sb_compare(2, {bus_if.c0_ack, bus_if.c0_err, bus_if.c0_rdata,
                       bus_if.c1_ack, bus_if.c1_err, bus_if.c1_rdata});
    end
  end

  task automatic set_req(input int id, input logic req, input logic we,
                         input logic [1:0] a, input logic [7:0] wd);
    if (id == 0) begin
      bus_if.c0_req = req; bus_if.c0_we = we; bus_if.c0_addr = a; bus_if.c0_wdata = wd;
    end else begin
      bus_if.c1_req = req; bus_if.c1_we = we; bus_if.c1_addr = a; bus_if.c1_wdata = wd;
    end
  endtask

  // Hold a request until its ack, then drop it at the following edge.
  task automatic client_txn(input int id, input logic we, input logic [1:0] a, input logic [7:0] wd);
    bit seen;
    seen = 0;
    set_req(id, 1'b1, we, a, wd);
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if ((id == 0) ? bus_if.c0_ack : bus_if.c1_ack) seen = 1;
    end
    if (!seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL c%0d_ack_timeout got no ack want ack within 40 cycles", id);
    end
    @(posedge clk);
    #1;
    set_req(id, 1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst        = 1'b1;
    br_cfg     = 2'b01;
    spart_data = 8'h00;
    set_req(0, 1'b0, 1'b0, 2'b00, 8'h00);
    set_req(1, 1'b0, 1'b0, 2'b00, 8'h00);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_iocs",     32'(iocs), 32'd0);
    check("rst_iorw",     32'(iorw), 32'd1);
    check("rst_ioaddr",   32'(ioaddr), 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_acks",     32'({bus_if.c0_ack, bus_if.c1_ack, bus_if.c0_err, bus_if.c1_err}), 32'd0);
    check("rst_rdata",    32'({bus_if.c0_rdata, bus_if.c1_rdata}), 32'd0);

    // Reset release with br_cfg=01 -> divisor 650 = 0x028A
    @(posedge clk); #1;
    r = cyc;
    push_bus(r + 1, 1'b0, 2'b10, 8'h8A);
    push_bus(r + 2, 1'b0, 2'b11, 8'h02);
    push_cfg(r + 3, 1'b1);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // c0 write buffer 0x41
    @(posedge clk); #1;
    r = cyc;
    push_bus(r + 1, 1'b0, 2'b00, 8'h41);
    push_ack(r + 2, 0, 1'b0, 8'h00);
    client_txn(0, 1'b1, 2'b00, 8'h41);

    // c1 read status, SPART returns 0xC3
    @(posedge clk); #1;
    r = cyc;
    spart_data = 8'hC3;
    push_bus(r + 1, 1'b1, 2'b01, 8'hC3);
    push_ack(r + 2, 1, 1'b0, 8'hC3);
    client_txn(1, 1'b0, 2'b01, 8'h00);

    // Both clients requesting back to back: c0, c1, c0, c1 every 3 cycles
    @(posedge clk); #1;
    r = cyc;
    spart_data = 8'h5C;
    push_bus(r + 1,  1'b0, 2'b00, 8'h11);
    push_ack(r + 2,  0, 1'b0, 8'h00);
    push_bus(r + 4,  1'b1, 2'b00, 8'h5C);
    push_ack(r + 5,  1, 1'b0, 8'h5C);
    push_bus(r + 7,  1'b0, 2'b00, 8'h22);
    push_ack(r + 8,  0, 1'b0, 8'h00);
    push_bus(r + 10, 1'b1, 2'b00, 8'h5C);
    push_ack(r + 11, 1, 1'b0, 8'h5C);
    fork
      begin
        client_txn(0, 1'b1, 2'b00, 8'h11);
        client_txn(0, 1'b1, 2'b00, 8'h22);
      end
      begin
        client_txn(1, 1'b0, 2'b00, 8'h00);
        client_txn(1, 1'b0, 2'b00, 8'h00);
      end
    join

    // c1 write to divisor address: error ack, no bus cycle
    @(posedge clk); #1;
    r = cyc;
    push_ack(r + 1, 1, 1'b1, 8'h00);
    client_txn(1, 1'b1, 2'b10, 8'h99);

    // br_cfg 01->00 during a c0 access, c1 held through reprogramming
    @(posedge clk); #1;
    r = cyc;
    spart_data = 8'hE7;
    push_bus(r + 1, 1'b0, 2'b00, 8'h5A);
    push_ack(r + 2, 0, 1'b0, 8'h00);
    push_cfg(r + 4, 1'b0);
    push_bus(r + 5, 1'b0, 2'b10, 8'h15);
    push_bus(r + 6, 1'b0, 2'b11, 8'h05);
    push_cfg(r + 7, 1'b1);
    push_bus(r + 7, 1'b1, 2'b00, 8'hE7);
    push_ack(r + 8, 1, 1'b0, 8'hE7);
    fork
      client_txn(0, 1'b1, 2'b00, 8'h5A);
      begin
        @(posedge clk); #1;
        br_cfg = 2'b00;
        @(posedge clk); #1;
        client_txn(1, 1'b0, 2'b00, 8'h00);
      end
    join

    // Reset in the middle of an access: no ack, reprogramming restarts
    @(posedge clk); #1;
    r = cyc;
    push_bus(r + 1, 1'b0, 2'b00, 8'h33);
    push_cfg(r + 2, 1'b0);
    push_bus(r + 3, 1'b0, 2'b10, 8'h15);
    push_bus(r + 4, 1'b0, 2'b11, 8'h05);
    push_cfg(r + 5, 1'b1);
    set_req(0, 1'b1, 1'b1, 2'b00, 8'h33);
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 2'b00, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_iocs", 32'(iocs), 32'd0);
    check("rstmid_ack",  32'({bus_if.c0_ack, bus_if.c1_ack}), 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("sb_remaining", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
